// File: rtl/addbit_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : addbit_serial_ctrl
// Purpose  : Bit-serial sequencer for one external 1-bit full adder (addbit).
//            Takes a WIDTH-bit operand pair and feeds it to the adder LSB
//            first. Each bit is held for SETTLE cycles, then sum/carry are
//            sampled. The assembled result is returned over a valid/ready
//            handshake.
// Options  : `define ADDBIT_SERIAL_SUB_EN adds the req_sub port. With
//            req_sub=1 the block computes A - B, and res_cout=1 means
//            no borrow.
// Revision : 1.0 - initial release
// ============================================================================
module addbit_serial_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
`ifdef ADDBIT_SERIAL_SUB_EN
    input  logic             req_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_sum,
    input  logic             add_co,
    output logic             busy
);

    localparam int c_BW = $clog2(WIDTH);
    localparam int c_SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_BW-1:0] c_LAST_BIT    = c_BW'(WIDTH - 1);
    localparam logic [c_SW-1:0] c_SETTLE_LOAD = c_SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_res_valid;
    logic              r_ready_en;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [c_SW-1:0]   r_settle;

    logic              w_accept;
    logic              w_res_take;
    logic              w_last_bit;
    logic [WIDTH-1:0]  w_b_load;
    logic              w_cin_load;

    // In subtract mode, B is inverted and the carry-in is forced to 1
    // (two's complement A + ~B + 1).
`ifdef ADDBIT_SERIAL_SUB_EN
    assign w_b_load   = req_sub ? ~req_b : req_b;
    assign w_cin_load = req_sub | req_cin;
`else
    assign w_b_load   = req_b;
    assign w_cin_load = req_cin;
`endif

    // req_ready stays low while reset is active. r_ready_en holds it low
    // until the first clock edge after reset is released.
    assign req_ready  = r_ready_en && (r_state == S_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_res_take = r_res_valid && res_ready;
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // The adder inputs come straight from registers. They change only when
    // a bit is loaded, so they are stable for the whole DRIVE window.
    assign add_a     = r_a[0];
    assign add_b     = r_b[0];
    assign add_ci    = r_carry;
    assign res_sum   = r_sum;
    assign res_cout  = r_cout;
    assign res_valid = r_res_valid;
    assign busy      = (r_state == S_DRIVE) || (r_state == S_SAMPLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_DRIVE;
            S_DRIVE:  if (r_settle == '0) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = w_last_bit ? S_DONE : S_DRIVE;
            S_DONE:   if (w_res_take) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand shift registers, carry, counters and result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_res_valid <= 1'b0;
            r_ready_en  <= 1'b0;
            r_bit_cnt   <= '0;
            r_settle    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a       <= req_a;
                        r_b       <= w_b_load;
                        r_carry   <= w_cin_load;
                        r_bit_cnt <= '0;
                        r_settle  <= c_SETTLE_LOAD;
                    end
                end
                S_DRIVE: begin
                    if (r_settle != '0) r_settle <= r_settle - 1'b1;
                end
                S_SAMPLE: begin
                    // The sum enters at the MSB and shifts right. After
                    // WIDTH samples, bit 0 sits at r_sum[0].
                    r_sum <= {add_sum, r_sum[WIDTH-1:1]};
                    if (w_last_bit) begin
                        // The operand registers and carry are not shifted,
                        // so the adder inputs keep their last-bit values.
                        r_cout <= add_co;
                    end else begin
                        r_a       <= r_a >> 1;
                        r_b       <= r_b >> 1;
                        r_carry   <= add_co;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_settle  <= c_SETTLE_LOAD;
                    end
                end
                S_DONE: begin
                    // res_valid rises one cycle after entering DONE and
                    // drops on the edge that completes the handshake.
                    r_res_valid <= !w_res_take;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addbit_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_addbit_serial_ctrl
// Purpose  : Directed self-checking bench for addbit_serial_ctrl
//            (WIDTH=8, SETTLE=2). It models the external full adder.
//            The subtract tests build only when ADDBIT_SERIAL_SUB_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addbit_serial_ctrl;

    localparam int W   = 8;
    localparam int ST  = 2;
    localparam int LAT = W * (ST + 1) + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
    logic         req_sub = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         add_a, add_b, add_ci;
    logic         add_sum, add_co;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // External 1-bit full adder
    assign add_sum = add_a ^ add_b ^ add_ci;
    assign add_co  = (add_a & add_b) | (add_a & add_ci) | (add_b & add_ci);

    addbit_serial_ctrl #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDBIT_SERIAL_SUB_EN
        .req_sub   (req_sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_sum   (add_sum),
        .add_co    (add_co),
        .busy      (busy)
    );

    // Carry into bit i for a + b + c
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input int i);
        logic [W-1:0] m;
        logic [W:0]   s;
        m = (W'(1) << i) - W'(1);
        s = {1'b0, a & m} + {1'b0, b & m} + {{W{1'b0}}, c};
        return s[i];
    endfunction

    // Present a request and return just after its accepting edge
    task automatic do_request(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub);
        int n;
        @(negedge clk);
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL req_accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({req_ready, res_valid, res_cout, add_a, add_b, add_ci, busy, res_sum} !== '0) begin
            fails++;
            $display("FAIL reset_values: rdy=%0b vld=%0b cout=%0b a/b/ci=%0b%0b%0b busy=%0b sum=%h required all 0",
                     req_ready, res_valid, res_cout, add_a, add_b, add_ci, busy, res_sum);
        end
        @(negedge clk) rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_clk: req_ready=%0b required 0", req_ready);
        end
        @(posedge clk) #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_clk: req_ready=%0b required 1", req_ready);
        end
    endtask

    // A full transaction: checks the adder drive sequence, latency,
    // result and handshake
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        logic [W-1:0] eb;
        logic         ec;
        logic [3:0]   exp_v;
        int           k;
        int           i;
        eb = sub ? ~b : b;
        ec = sub ? 1'b1 : cin;
        do_request(a, b, cin, sub);
        k = 0;
        while (!res_valid && k < 200) begin
            if (k < W * (ST + 1)) begin
                i = k / (ST + 1);
                exp_v = {1'b1, a[i], eb[i], carry_into(a, eb, ec, i)};
                tests++;
                if ({busy, add_a, add_b, add_ci} !== exp_v) begin
                    fails++;
                    $display("FAIL %s_drive cycle %0d: busy/a/b/ci=%b required %b",
                             name, k, {busy, add_a, add_b, add_ci}, exp_v);
                end
            end
            @(posedge clk) #1;
            k++;
        end
        tests++;
        if (k !== LAT || res_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_latency: %0d cycles (valid=%0b) required %0d", name, k, res_valid, LAT);
        end
        tests++;
        if ({res_cout, res_sum} !== {exp_cout, exp_sum}) begin
            fails++;
            $display("FAIL %s_result: cout=%0b sum=%h required cout=%0b sum=%h",
                     name, res_cout, res_sum, exp_cout, exp_sum);
        end
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk) #1;
        tests++;
        if ({res_valid, req_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL %s_handshake: vld/rdy/busy=%b required 010", name, {res_valid, req_ready, busy});
        end
        @(negedge clk) res_ready = 1'b0;
    endtask

    task automatic test_add();
        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
    endtask

    task automatic test_back_to_back();
        int k;
        do_request(8'h5A, 8'h33, 1'b0, 1'b0);
        k = 0;
        while (!res_valid && k < 200) begin
            @(posedge clk) #1;
            k++;
        end
        @(negedge clk);
        req_a = 8'h01; req_b = 8'h02; req_cin = 1'b0; req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk) #1;
            tests++;
            if ({res_valid, req_ready, busy, res_cout, res_sum} !== {4'b1000, 8'h8D}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: vld/rdy/busy/cout=%b sum=%h required 1000 sum=8d",
                         c, {res_valid, req_ready, busy, res_cout}, res_sum);
            end
        end
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk) #1;
        tests++;
        if ({res_valid, req_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL bp_release: vld/rdy/busy=%b required 010", {res_valid, req_ready, busy});
        end
        @(negedge clk) res_ready = 1'b0;
        @(posedge clk) #1 req_valid = 1'b0;
        tests++;
        if ({busy, req_ready} !== 2'b10) begin
            fails++;
            $display("FAIL bp_second_accept: busy/rdy=%b required 10", {busy, req_ready});
        end
        k = 0;
        while (!res_valid && k < 200) begin
            @(posedge clk) #1;
            k++;
        end
        tests++;
        if (k !== LAT || {res_cout, res_sum} !== 9'h003) begin
            fails++;
            $display("FAIL bp_second_result: lat=%0d cout=%0b sum=%h required lat=%0d cout=0 sum=03",
                     k, res_cout, res_sum, LAT);
        end
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk) #1;
        @(negedge clk) res_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        do_request(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (12) @(posedge clk);
        #3;
        tests++;
        if ({busy, add_a, add_b, add_ci} !== 4'b1111) begin
            fails++;
            $display("FAIL abort_pre: busy/a/b/ci=%b required 1111", {busy, add_a, add_b, add_ci});
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({req_ready, res_valid, res_cout, add_a, add_b, add_ci, busy, res_sum} !== '0) begin
            fails++;
            $display("FAIL abort_reset: rdy=%0b vld=%0b cout=%0b a/b/ci=%0b%0b%0b busy=%0b sum=%h required all 0",
                     req_ready, res_valid, res_cout, add_a, add_b, add_ci, busy, res_sum);
        end
        @(negedge clk) rst = 1'b0;
        run_op("abort_recover", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
    endtask

`ifdef ADDBIT_SERIAL_SUB_EN
    task automatic test_sub();
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_reset_abort();
`ifdef ADDBIT_SERIAL_SUB_EN
        test_sub();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
